// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - Fibonacci PRBS generator and self-synchronising PRBS checker with BER counters
module prbs_gen_chk #(
  parameter int           N         = 9,
  parameter logic [N-1:0] POLY      = 9'h021,
  parameter int           W         = 1,
  parameter int           LOCK_BITS = 64,
  parameter int           WIN_BEATS = 32,
  parameter int           LOSS_THR  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         gen_en,
  input  logic         seed_load,
  input  logic [N-1:0] seed,
  output logic [W-1:0] gen_data,
  output logic         gen_valid,
  input  logic         chk_valid,
  input  logic [W-1:0] chk_data,
  input  logic         cnt_clr,
  output logic         locked,
  output logic [31:0]  err_cnt,
  output logic [31:0]  bit_cnt
);
  localparam int FW  = $clog2(N + 1);
  localparam int GW  = $clog2(LOCK_BITS + W + 1);
  localparam int EW  = $clog2(W + 1);
  localparam int WEW = $clog2(LOSS_THR + W + 1);
  localparam int WBW = $clog2(WIN_BEATS + 1);

  typedef enum logic {SEARCH, LOCKED} chk_state_t;

  logic [N-1:0]   gen_s;
  logic [N-1:0]   gen_s_adv;
  logic [W-1:0]   gen_bits;

  chk_state_t     state;
  chk_state_t     state_nxt;
  logic [N-1:0]   hist;
  logic [N-1:0]   hist_nxt;
  logic [FW-1:0]  fill;
  logic [FW-1:0]  fill_run;
  logic [GW-1:0]  good;
  logic [GW-1:0]  good_nxt;
  logic [WEW-1:0] win_err;
  logic [WEW-1:0] win_err_nxt;
  logic [WEW-1:0] win_err_sum;
  logic [WBW-1:0] win_beats;
  logic [WBW-1:0] win_beats_nxt;
  logic [W-1:0]   err_bits;
  logic [EW-1:0]  err_pop;
  logic [31:0]    err_q;
  logic [31:0]    bit_q;
  logic [31:0]    err_nxt;
  logic [31:0]    bit_nxt;
  logic [32:0]    err_sum;
  logic [32:0]    bit_sum;

  // W LFSR steps unrolled from the current state; bit 0 is the earliest output.
  always_comb begin
    gen_s_adv = gen_s;
    gen_bits  = '0;
    for (int j = 0; j < W; j++) begin
      gen_bits[j] = gen_s_adv[0];
      gen_s_adv   = {^(gen_s_adv & POLY), gen_s_adv[N-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_s     <= N'(1);
      gen_data  <= '0;
      gen_valid <= 1'b0;
    end else if (seed_load) begin
      gen_s     <= (seed == '0) ? N'(1) : seed;
      gen_valid <= 1'b0;
    end else if (gen_en) begin
      gen_s     <= gen_s_adv;
      gen_data  <= gen_bits;
      gen_valid <= 1'b1;
    end else begin
      gen_valid <= 1'b0;
    end
  end

  // Each received bit is predicted from the N bits received before it.
  always_comb begin
    hist_nxt = hist;
    fill_run = fill;
    err_bits = '0;
    err_pop  = '0;
    for (int j = 0; j < W; j++) begin
      if (fill_run == FW'(N)) begin
        err_bits[j] = chk_data[j] ^ (^(hist_nxt & POLY));
      end
      hist_nxt = {chk_data[j], hist_nxt[N-1:1]};
      if (fill_run != FW'(N)) begin
        fill_run = fill_run + FW'(1);
      end
      err_pop = err_pop + EW'(err_bits[j]);
    end
  end

  always_comb begin
    state_nxt     = state;
    good_nxt      = good;
    win_err_nxt   = win_err;
    win_beats_nxt = win_beats;
    err_nxt       = err_q;
    bit_nxt       = bit_q;
    win_err_sum   = win_err + WEW'(err_pop);
    err_sum       = {1'b0, err_q} + 33'(err_pop);
    bit_sum       = {1'b0, bit_q} + 33'(W);
    if (chk_valid) begin
      case (state)
        SEARCH: begin
          if (err_pop != '0 || fill != FW'(N)) begin
            good_nxt = '0;
          end else begin
            good_nxt = good + GW'(W);
            if (good + GW'(W) >= GW'(LOCK_BITS)) begin
              state_nxt     = LOCKED;
              win_err_nxt   = '0;
              win_beats_nxt = '0;
            end
          end
        end
        LOCKED: begin
          err_nxt = err_sum[32] ? '1 : err_sum[31:0];
          bit_nxt = bit_sum[32] ? '1 : bit_sum[31:0];
          if (win_err_sum >= WEW'(LOSS_THR)) begin
            state_nxt     = SEARCH;
            good_nxt      = '0;
            win_err_nxt   = '0;
            win_beats_nxt = '0;
          end else if (win_beats == WBW'(WIN_BEATS - 1)) begin
            win_err_nxt   = '0;
            win_beats_nxt = '0;
          end else begin
            win_err_nxt   = win_err_sum;
            win_beats_nxt = win_beats + WBW'(1);
          end
        end
      endcase
    end
    // A clear discards any increment from the same beat.
    if (cnt_clr) begin
      err_nxt = '0;
      bit_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      hist      <= '0;
      fill      <= '0;
      good      <= '0;
      win_err   <= '0;
      win_beats <= '0;
      err_q     <= '0;
      bit_q     <= '0;
    end else begin
      state     <= state_nxt;
      good      <= good_nxt;
      win_err   <= win_err_nxt;
      win_beats <= win_beats_nxt;
      err_q     <= err_nxt;
      bit_q     <= bit_nxt;
      if (chk_valid) begin
        hist <= hist_nxt;
        fill <= fill_run;
      end
    end
  end

  assign locked  = (state == LOCKED);
  assign err_cnt = err_q;
  assign bit_cnt = bit_q;

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised PRBS (m-sequence) generator and self-synchronising checker for link BER experiments.
- Generator: Fibonacci LFSR of degree N with a configurable tap mask, W bits produced per clock, runtime seed load and enable.
- Checker: predicts each received bit from previously received bits, acquires lock, and counts bit errors and checked bits.
- Sits between the test-pattern controller and the modulator/demodulator datapath.

Parameters:
N, 9, LFSR degree; legal range 2..32
POLY, 9'h021, tap mask; bit i set means state bit i feeds the XOR. Default gives x^9+x^5+1, period 511.
W, 1, bits per beat; legal range 1..N
LOCK_BITS, 64, consecutive error-free checked bits needed to declare lock
WIN_BEATS, 32, loss-of-lock observation window, in valid beats
LOSS_THR, 8, errors within one window that force loss of lock

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
gen_en  input  1  advance generator by W steps this cycle
seed_load  input  1  load seed into generator state; has priority over gen_en
seed  input  N  seed value; 0 is replaced by 1
gen_data  output  W  generated bits; bit 0 is earliest in sequence
gen_valid  output  1  gen_data valid strobe
chk_valid  input  1  chk_data beat valid
chk_data  input  W  received bits; bit 0 is earliest
cnt_clr  input  1  synchronous clear of err_cnt and bit_cnt
locked  output  1  checker in LOCKED state
err_cnt  output  32  bit errors counted while LOCKED; saturating
bit_cnt  output  32  bits checked while LOCKED; saturating

Behaviour:
- Reset values:
  - Generator: state = 1, gen_data = 0, gen_valid = 0.
  - Checker: history = 0, fill = 0, good = 0, window counters = 0, state SEARCH, locked = 0, err_cnt = 0, bit_cnt = 0.
  - Reset mid-operation aborts everything immediately.
- LFSR single step:
  - out = s[0]
  - fb = XOR of (s & POLY)
  - s' = {fb, s[N-1:1]}
- Generator, per cycle:
  - seed_load = 1: s <= (seed == 0 ? 1 : seed); gen_valid <= 0; gen_data holds.
  - Else gen_en = 1: gen_data[j] <= out of step j (j = 0..W-1, unrolled from current s); s <= state after W steps; gen_valid <= 1.
  - Else: gen_valid <= 0; gen_data and s hold.
  - Latency: 1 cycle, registered.
  - All-zero state is unreachable.
- Checker prediction, per valid beat:
  - Bits are processed in order j = 0..W-1 through an N-bit history h of received bits, using the same step rule.
  - pred = XOR of (h & POLY); e_j = chk_data[j] ^ pred; h <= {chk_data[j], h[N-1:1]}.
  - Predicted errors are counted only once fill >= N. fill counts received bits and saturates at N.
  - One channel error produces up to popcount(POLY) + 1 flagged errors. This is accepted; no correction is applied.
- Checker FSM:
  - SEARCH:
    - A beat with any counted e_j, or with fill < N at beat start: good <= 0.
    - Otherwise: good <= good + W.
    - good + W >= LOCK_BITS: go to LOCKED; clear window counters; locked <= 1 next cycle.
  - LOCKED:
    - Per valid beat: err_cnt += popcount(e); bit_cnt += W; win_err += popcount(e); win_beats += 1.
    - win_err (including this beat) >= LOSS_THR: go to SEARCH; good <= 0; locked <= 0; this beat's errors are still counted.
    - Else if win_beats reaches WIN_BEATS: window counters reset to 0.
  - chk_valid = 0: nothing changes.
- Counters:
  - Saturate at 32'hFFFF_FFFF; no wrap.
  - cnt_clr wins over a same-cycle increment: the result is 0, and that beat's increment is discarded.
  - cnt_clr does not affect FSM, history or window counters.
- Simultaneous events:
  - seed_load and gen_en together: seed_load wins.
  - Generator and checker are independent; both may be active in the same cycle.
- Counter and locked updates are visible 1 cycle after the valid beat.

Test Plan:
- Reset, N=9, W=1, POLY default; gen_en held high. Required:
  - gen_valid rises 1 cycle later.
  - First 10 bits are 1,0,0,0,0,0,0,0,0,1.
  - Sequence repeats exactly every 511 beats with 256 ones per period.
- Loop gen_data into chk_data with chk_valid = gen_valid, W=1. Required:
  - locked = 1 after 9 fill bits + 64 clean bits, i.e. on the cycle after the 73rd beat.
  - err_cnt stays 0; bit_cnt increments by 1 per beat.
- Locked loopback; invert a single bit. Required:
  - err_cnt rises by 3 (popcount(POLY) + 1).
  - locked stays 1.
- Locked; invert every chk_data bit for 4 consecutive beats. Required:
  - win_err reaches >= 8 within the window, so locked -> 0.
  - Then re-lock 73 clean beats after the corruption ends.
- seed_load with seed = 0, then gen_en. Required:
  - Same output as after reset (state 1).
  - gen_valid = 0 in the load cycle.
  - seed_load + gen_en together: load wins.
- W=4 loopback, plus cnt_clr asserted on a beat that carries errors. Required:
  - gen_data = 4'b0001 on the first beat; locked after ceil(73/4) beats.
  - err_cnt = 0 after the cnt_clr cycle.
  - Counters preset near 2^32-1 saturate at all-ones.
